controle_jogo_sequencia: RTL and testbench
==========================================

CONTROLE_JOGO_SEQUENCIA -- requirements
Module: controle_jogo_sequencia

Interface
REQ-001 Parameter N_JOGADAS, default 16: rounds per game and memory depth, 2..16.
REQ-002 Parameter TIMEOUT_CICLOS, default 5000: clock cycles allowed per jogada, 2..65535.
REQ-003 Port list, one per line:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- iniciar  in  1  level; start or restart game.
- jogada_feita  in  1  one-cycle pulse per button press (edge-detected upstream).
- igual  in  1  compare result (botoes == memoria[endereco]), valid in state COMPARACAO.
- endereco  out  4  memory address of expected jogada.
- registra  out  1  one-cycle load strobe for the botoes register.
- acertou  out  1  game won.
- errou  out  1  game lost (wrong jogada or timeout).
- pronto  out  1  game finished.
- db_estado  out  4  current state code.
- db_rodada  out  4  current round index.
- db_timeout  out  1  loss caused by timeout.

Function
REQ-004 Moore FSM, codes: INICIAL 0, PREPARACAO 1, ESPERA 2, REGISTRA 3, COMPARACAO 4, PROX_JOGADA 5, PROX_RODADA 6, FIM_ACERTO A, FIM_ERRO E, FIM_TIMEOUT D; db_estado = code.
REQ-005 INICIAL: iniciar=1 -> PREPARACAO; else stay.
REQ-006 PREPARACAO: endereco<=0, rodada<=0, timeout counter<=0; unconditionally -> ESPERA.
REQ-007 ESPERA: timeout counter +1 per cycle; jogada_feita=1 -> REGISTRA; counter == TIMEOUT_CICLOS-1 with no jogada_feita -> FIM_TIMEOUT.
REQ-008 Simultaneous jogada_feita and timeout terminal count: jogada wins -> REGISTRA.
REQ-009 REGISTRA: registra=1 for exactly this one cycle -> COMPARACAO.
REQ-010 COMPARACAO: igual=0 -> FIM_ERRO; igual=1, endereco<rodada -> PROX_JOGADA; igual=1, endereco==rodada, rodada<N_JOGADAS-1 -> PROX_RODADA; igual=1, endereco==rodada==N_JOGADAS-1 -> FIM_ACERTO.
REQ-011 PROX_JOGADA: endereco+1, timeout counter<=0 -> ESPERA.
REQ-012 PROX_RODADA: rodada+1, endereco<=0, timeout counter<=0 -> ESPERA.
REQ-013 FIM_*: pronto=1; FIM_ACERTO acertou=1; FIM_ERRO errou=1; FIM_TIMEOUT errou=1, db_timeout=1; iniciar=1 -> PREPARACAO, else hold.
REQ-014 acertou/errou/pronto/db_timeout decoded from state only; 0 in all other states.
REQ-015 iniciar ignored outside INICIAL and FIM_*; jogada_feita ignored outside ESPERA.
REQ-016 endereco and rodada never exceed N_JOGADAS-1; no wrap-around.
REQ-017 Round r (0-based) requires r+1 jogadas; full game = N_JOGADAS*(N_JOGADAS+1)/2 jogadas.

Reset
REQ-018 reset=0 at any time, including mid-game: state INICIAL, endereco=0, rodada=0, timeout counter=0, all outputs 0, db_estado=0, effective without a clock edge.
REQ-019 Registers leave reset on the first rising clock edge after reset returns to 1.

Configuration
REQ-020 Macro CONTROLE_JOGO_TIMEOUT_EN defined: timeout counter and FIM_TIMEOUT present per REQ-007/008/013.
REQ-021 Macro undefined: no timeout counter, ESPERA waits indefinitely, FIM_TIMEOUT unreachable, db_timeout tied 0; parameter TIMEOUT_CICLOS accepted but unused.

Verification
REQ-022 Reset, iniciar=1 for 1 cycle -> db_estado 0->1->2, endereco=0, db_rodada=0, pronto=0.
REQ-023 N_JOGADAS=4, igual=1 on every jogada, 10 pulses -> rodada steps 0,1,2,3; final state A, acertou=1, pronto=1, endereco=3.
REQ-024 Round 2, igual=0 on the second jogada -> state E, errou=1, pronto=1, endereco=1, db_rodada=2.
REQ-025 TIMEOUT_EN defined, TIMEOUT_CICLOS=10, no jogada in ESPERA -> state D 10 cycles after ESPERA entry, errou=1, db_timeout=1; undefined -> remains state 2 for 100 cycles.
REQ-026 jogada_feita on the terminal-count cycle -> state 3 next cycle, no timeout.
REQ-027 reset=0 pulse in state 4 mid-round 3 -> all outputs 0 immediately; later iniciar starts a fresh game at rodada 0.

Source files
------------

// File: rtl/controle_jogo_sequencia_if.sv
// controle_jogo_sequencia_if: game-controller bus (master drives iniciar/jogada_feita/igual, slave returns status, memory address, registra strobe and debug)
interface controle_jogo_sequencia_if;
  logic       iniciar;
  logic       jogada_feita;
  logic       igual;
  logic [3:0] endereco;
  logic       registra;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic [3:0] db_estado;
  logic [3:0] db_rodada;
  logic       db_timeout;
  modport master (
    output iniciar, jogada_feita, igual,
    input  endereco, registra, acertou, errou, pronto, db_estado, db_rodada, db_timeout
  );
  modport slave (
    input  iniciar, jogada_feita, igual,
    output endereco, registra, acertou, errou, pronto, db_estado, db_rodada, db_timeout
  );
endinterface

// File: rtl/controle_jogo_sequencia.sv
// controle_jogo_sequencia: sequence-game Moore FSM; ports clock, reset (async active-low), bus (slave: iniciar/jogada_feita/igual in; endereco/registra/acertou/errou/pronto/db_* out); CONTROLE_JOGO_TIMEOUT_EN enables the per-jogada timeout
module controle_jogo_sequencia #(
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic                      clock,
  input logic                      reset,
  controle_jogo_sequencia_if.slave bus
);
  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARACAO  = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h3;
  localparam logic [3:0] COMPARACAO  = 4'h4;
  localparam logic [3:0] PROX_JOGADA = 4'h5;
  localparam logic [3:0] PROX_RODADA = 4'h6;
  localparam logic [3:0] FIM_ACERTO  = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] FIM_ERRO    = 4'hE;
  localparam logic [3:0] ULTIMA      = 4'(N_JOGADAS - 1);
  if (N_JOGADAS < 2 || N_JOGADAS > 16 || TIMEOUT_CICLOS < 2 || TIMEOUT_CICLOS > 65535) begin : g_param_invalido
    $error("controle_jogo_sequencia: parameter out of range");
  end
  logic [3:0] estado, prox;
  logic [3:0] endereco, rodada;
  logic       fim_cont;
  logic       zera;
  assign zera = estado == PREPARACAO || estado == PROX_JOGADA || estado == PROX_RODADA;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
  logic [15:0] cont;
  assign fim_cont = cont == 16'(TIMEOUT_CICLOS - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cont <= '0;
    else cont <= zera ? '0 : estado == ESPERA ? cont + 16'd1 : cont;
`else
  assign fim_cont = 1'b0;
`endif
  // jogada_feita takes priority over the timeout terminal count
  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:                         prox = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:                      prox = ESPERA;
      ESPERA:                          prox = bus.jogada_feita ? REGISTRA : fim_cont ? FIM_TIMEOUT : ESPERA;
      REGISTRA:                        prox = COMPARACAO;
      COMPARACAO:                      prox = !bus.igual ? FIM_ERRO : endereco != rodada ? PROX_JOGADA :
                                              rodada != ULTIMA ? PROX_RODADA : FIM_ACERTO;
      PROX_JOGADA, PROX_RODADA:        prox = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: prox = bus.iniciar ? PREPARACAO : estado;
      default:                         prox = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado   <= INICIAL;
      endereco <= '0;
      rodada   <= '0;
    end else begin
      estado   <= prox;
      endereco <= (estado == PREPARACAO || estado == PROX_RODADA) ? 4'd0 :
                  (estado == PROX_JOGADA && endereco != ULTIMA) ? endereco + 4'd1 : endereco;
      rodada   <= estado == PREPARACAO ? 4'd0 :
                  (estado == PROX_RODADA && rodada != ULTIMA) ? rodada + 4'd1 : rodada;
    end
  assign bus.endereco   = endereco;
  assign bus.registra   = estado == REGISTRA;
  assign bus.acertou    = estado == FIM_ACERTO;
  assign bus.errou      = estado == FIM_ERRO || estado == FIM_TIMEOUT;
  assign bus.pronto     = estado == FIM_ACERTO || estado == FIM_ERRO || estado == FIM_TIMEOUT;
  assign bus.db_estado  = estado;
  assign bus.db_rodada  = rodada;
  assign bus.db_timeout = estado == FIM_TIMEOUT;
endmodule

// File: tb/tb_controle_jogo_sequencia.sv
// tb_controle_jogo_sequencia: directed self-checking bench for controle_jogo_sequencia (N_JOGADAS=4, TIMEOUT_CICLOS=10)
module tb_controle_jogo_sequencia;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  controle_jogo_sequencia_if bus ();
  controle_jogo_sequencia #(.N_JOGADAS(4), .TIMEOUT_CICLOS(10)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic start;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
  endtask
  task automatic press(input logic ig, output logic reg_seen);
    bus.jogada_feita = 1'b1;
    tick();
    reg_seen = bus.registra;
    bus.jogada_feita = 1'b0;
    bus.igual = ig;
    tick();
    tick();
  endtask
  task automatic test_reset;
    reset = 1'b0;
    bus.iniciar = 1'b0;
    bus.jogada_feita = 1'b0;
    bus.igual = 1'b0;
    #2;
    checks++;
    if ({bus.db_estado, bus.endereco, bus.db_rodada, bus.registra, bus.acertou, bus.errou, bus.pronto, bus.db_timeout} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got estado=%h end=%h rod=%h flags=%b%b%b%b%b want all 0", bus.db_estado, bus.endereco,
               bus.db_rodada, bus.registra, bus.acertou, bus.errou, bus.pronto, bus.db_timeout);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.db_estado !== 4'h0) begin errors++; $display("FAIL idle_state got %h want 0", bus.db_estado); end
    bus.iniciar = 1'b1;
    tick();
    checks++;
    if (bus.db_estado !== 4'h1) begin errors++; $display("FAIL prep_state got %h want 1", bus.db_estado); end
    bus.iniciar = 1'b0;
    tick();
    checks++;
    if ({bus.db_estado, bus.endereco, bus.db_rodada, bus.pronto} !== {4'h2, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL espera_entry got estado=%h end=%h rod=%h pronto=%b want 2 0 0 0", bus.db_estado, bus.endereco, bus.db_rodada, bus.pronto);
    end
  endtask
  task automatic test_win;
    logic rs;
    logic [3:0] exp;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    checks++;
    if (bus.db_estado !== 4'h2) begin errors++; $display("FAIL iniciar_ignored got %h want 2", bus.db_estado); end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j <= r; j++) begin
        press(1'b1, rs);
        checks++;
        if (rs !== 1'b1) begin errors++; $display("FAIL registra_strobe r=%0d j=%0d got %b want 1", r, j, rs); end
        exp = (j < r) ? 4'h5 : (r < 3) ? 4'h6 : 4'hA;
        checks++;
        if (bus.db_estado !== exp) begin errors++; $display("FAIL win_next r=%0d j=%0d got %h want %h", r, j, bus.db_estado, exp); end
        if (exp != 4'hA) begin
          tick();
          checks++;
          if ({bus.db_estado, bus.endereco, bus.db_rodada} !== {4'h2, (j < r) ? 4'(j + 1) : 4'd0, (j < r) ? 4'(r) : 4'(r + 1)}) begin
            errors++;
            $display("FAIL win_espera r=%0d j=%0d got estado=%h end=%h rod=%h", r, j, bus.db_estado, bus.endereco, bus.db_rodada);
          end
        end
      end
    checks++;
    if ({bus.acertou, bus.errou, bus.pronto, bus.registra, bus.endereco, bus.db_rodada} !== {4'b1010, 4'h3, 4'h3}) begin
      errors++;
      $display("FAIL win_final got ac=%b er=%b pr=%b rg=%b end=%h rod=%h want 1 0 1 0 3 3", bus.acertou, bus.errou, bus.pronto,
               bus.registra, bus.endereco, bus.db_rodada);
    end
    bus.jogada_feita = 1'b1;
    tick();
    bus.jogada_feita = 1'b0;
    tick();
    checks++;
    if (bus.db_estado !== 4'hA) begin errors++; $display("FAIL fim_hold got %h want A", bus.db_estado); end
  endtask
  task automatic test_error;
    logic rs;
    start();
    checks++;
    if ({bus.db_estado, bus.endereco, bus.db_rodada} !== {4'h2, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL restart got estado=%h end=%h rod=%h want 2 0 0", bus.db_estado, bus.endereco, bus.db_rodada);
    end
    for (int r = 0; r < 2; r++)
      for (int j = 0; j <= r; j++) begin
        press(1'b1, rs);
        tick();
      end
    press(1'b1, rs);
    tick();
    press(1'b0, rs);
    checks++;
    if ({bus.db_estado, bus.errou, bus.pronto, bus.acertou, bus.endereco, bus.db_rodada} !== {4'hE, 3'b110, 4'h1, 4'h2}) begin
      errors++;
      $display("FAIL error_final got estado=%h er=%b pr=%b ac=%b end=%h rod=%h want E 1 1 0 1 2", bus.db_estado, bus.errou,
               bus.pronto, bus.acertou, bus.endereco, bus.db_rodada);
    end
  endtask
  task automatic test_timeout;
    int bad;
    start();
    bad = 0;
`ifdef CONTROLE_JOGO_TIMEOUT_EN
    for (int i = 1; i < 10; i++) begin
      tick();
      if (bus.db_estado !== 4'h2) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_early got %0d early exits want 0", bad); end
    tick();
    checks++;
    if ({bus.db_estado, bus.errou, bus.db_timeout, bus.pronto} !== {4'hD, 3'b111}) begin
      errors++;
      $display("FAIL timeout_state got estado=%h er=%b to=%b pr=%b want D 1 1 1", bus.db_estado, bus.errou, bus.db_timeout, bus.pronto);
    end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.db_estado !== 4'h2 || bus.db_timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL no_timeout got %0d cycles out of ESPERA want 0", bad); end
`endif
  endtask
  task automatic test_terminal_count;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    start();
    for (int i = 1; i < 10; i++) tick();
    bus.jogada_feita = 1'b1;
    tick();
    bus.jogada_feita = 1'b0;
    checks++;
    if ({bus.db_estado, bus.db_timeout, bus.registra} !== {4'h3, 2'b01}) begin
      errors++;
      $display("FAIL terminal_jogada got estado=%h to=%b rg=%b want 3 0 1", bus.db_estado, bus.db_timeout, bus.registra);
    end
    bus.igual = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.db_estado !== 4'h6) begin errors++; $display("FAIL terminal_continue got %h want 6", bus.db_estado); end
  endtask
  task automatic test_midgame_reset;
    logic rs;
    tick();
    for (int r = 1; r < 3; r++)
      for (int j = 0; j <= r; j++) begin
        press(1'b1, rs);
        tick();
      end
    bus.jogada_feita = 1'b1;
    tick();
    bus.jogada_feita = 1'b0;
    bus.igual = 1'b1;
    tick();
    checks++;
    if ({bus.db_estado, bus.db_rodada} !== {4'h4, 4'h3}) begin
      errors++;
      $display("FAIL pre_reset got estado=%h rod=%h want 4 3", bus.db_estado, bus.db_rodada);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.db_estado, bus.endereco, bus.db_rodada, bus.registra, bus.acertou, bus.errou, bus.pronto, bus.db_timeout} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset got estado=%h end=%h rod=%h want all 0", bus.db_estado, bus.endereco, bus.db_rodada);
    end
    #3;
    reset = 1'b1;
    tick();
    start();
    checks++;
    if ({bus.db_estado, bus.endereco, bus.db_rodada} !== {4'h2, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL fresh_game got estado=%h end=%h rod=%h want 2 0 0", bus.db_estado, bus.endereco, bus.db_rodada);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_win();
    test_error();
    test_timeout();
    test_terminal_count();
    test_midgame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
